// File: rtl/ysyx_lsu_if.sv
// ---------------------------------------------------------------------------
// ysyx_lsu_if -- signal bundle for the load/store unit.
//
// Groups the three handshakes the LSU takes part in:
//   command   : in_valid, in_ready, dm_rd_sel[2:0], dm_wr_sel[1:0],
//               addr[31:0], wdata[31:0]            (execute -> LSU)
//   result    : out_valid, out_ready, rdata[31:0], err (LSU -> writeback)
//   data bus  : mem_req, mem_we, mem_addr[31:0], mem_wdata[31:0],
//               mem_wstrb[3:0]                     (LSU -> memory)
//               mem_gnt, mem_rvalid, mem_rdata[31:0] (memory -> LSU)
//
// Modports:
//   slave  : the LSU itself
//   master : the surrounding pipeline and memory (or a testbench)
//
// Handshake rule shared by every valid/ready pair here: a transfer happens
// on a rising clock edge where both valid and ready are high; once valid is
// raised, the sender keeps valid and its payload unchanged until that edge.
// The memory request behaves the same way with mem_req/mem_gnt.
// ---------------------------------------------------------------------------
interface ysyx_lsu_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  dm_rd_sel;
   logic [1:0]  dm_wr_sel;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] rdata;
   logic        err;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport slave (
      input  in_valid, dm_rd_sel, dm_wr_sel, addr, wdata,
      input  out_ready,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output in_ready,
      output out_valid, rdata, err,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output in_valid, dm_rd_sel, dm_wr_sel, addr, wdata,
      output out_ready,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  in_ready,
      input  out_valid, rdata, err,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/ysyx_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_lsu -- single-outstanding load/store unit.
//
// Accepts one load/store command from the execute stage, issues at most one
// word-aligned request on the data bus, formats the load result or store
// strobes/data by byte lane, and hands the result to writeback.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        ysyx_lsu_if.slave (command, result and data-bus signals)
//   dbg_state  current FSM state (IDLE=0, REQ=1, WAIT=2, DONE=3)
//
// Optional feature: define YSYX_LSU_MISALIGN_CHECK_EN to reject misaligned
// halfword/word accesses (err=1, no bus request). Without it err is always 0
// and misaligned accesses use the ordinary lane rules on addr[1:0].
//
// All outputs come straight from flops updated in the single FSM block.
// ---------------------------------------------------------------------------
module ysyx_lsu (
   input  logic         clk,
   input  logic         rst_n,
   ysyx_lsu_if.slave    bus,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state;

   // Registered command. The word address and formatted store data are
   // held in the mem_addr/mem_wdata flops; only what the load formatter
   // needs later is kept separately.
   logic [2:0]  cmd_rd_sel;
   logic [1:0]  cmd_lane;

   logic        in_ready_q;
   logic        out_valid_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic [3:0]  mem_wstrb_q;

   // ------------------------------------------------------------------
   // Decode of the incoming command (only used on the accept edge)
   // ------------------------------------------------------------------
   logic        in_is_load;
   logic        in_is_store;
   logic        in_misalign;
   logic [3:0]  in_wstrb;
   logic [31:0] in_wdata_rep;

   always_comb begin
      in_is_load   = (bus.dm_rd_sel >= 3'd1) && (bus.dm_rd_sel <= 3'd5);
      // A valid load select wins; the store half of such a command is dropped.
      in_is_store  = (bus.dm_wr_sel != 2'b00) && !in_is_load;
      in_wstrb     = 4'b0000;
      in_wdata_rep = 32'h0000_0000;
      if (in_is_store) begin
         case (bus.dm_wr_sel)
            2'b01: begin
               in_wstrb     = 4'b0001 << bus.addr[1:0];
               in_wdata_rep = {4{bus.wdata[7:0]}};
            end
            2'b10: begin
               in_wstrb     = 4'b0011 << {bus.addr[1], 1'b0};
               in_wdata_rep = {2{bus.wdata[15:0]}};
            end
            default: begin
               in_wstrb     = 4'b1111;
               in_wdata_rep = bus.wdata;
            end
         endcase
      end
   end

`ifdef YSYX_LSU_MISALIGN_CHECK_EN
   always_comb begin
      in_misalign = 1'b0;
      if (in_is_load) begin
         case (bus.dm_rd_sel)
            3'd3, 3'd4: in_misalign = bus.addr[0];
            3'd5:       in_misalign = |bus.addr[1:0];
            default:    in_misalign = 1'b0;
         endcase
      end else if (in_is_store) begin
         case (bus.dm_wr_sel)
            2'b10:   in_misalign = bus.addr[0];
            2'b11:   in_misalign = |bus.addr[1:0];
            default: in_misalign = 1'b0;
         endcase
      end
   end
`else
   // No alignment checking: err can never be raised.
   assign in_misalign = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Load formatter: pick the lane from the captured address bits and
   // sign- or zero-extend. Halfwords use addr[1] only, so a halfword at an
   // odd address reads the half that contains it (no byte rotation).
   // ------------------------------------------------------------------
   function automatic logic [31:0] load_extract(
      input logic [2:0]  sel,
      input logic [1:0]  lane,
      input logic [31:0] word
   );
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (sel)
         3'd1:    load_extract = {{24{b[7]}}, b};
         3'd2:    load_extract = {24'h00_0000, b};
         3'd3:    load_extract = {{16{h[15]}}, h};
         3'd4:    load_extract = {16'h0000, h};
         3'd5:    load_extract = word;
         default: load_extract = 32'h0000_0000;
      endcase
   endfunction

   logic cmd_is_load;
   assign cmd_is_load = (cmd_rd_sel >= 3'd1) && (cmd_rd_sel <= 3'd5);

   // ------------------------------------------------------------------
   // FSM with registered outputs. Reset aborts whatever is in flight; the
   // bus request drops at once and nothing is replayed afterwards because
   // the command registers are cleared too.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cmd_rd_sel  <= 3'd0;
         cmd_lane    <= 2'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         rdata_q     <= 32'h0000_0000;
         err_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0000_0000;
         mem_wdata_q <= 32'h0000_0000;
         mem_wstrb_q <= 4'b0000;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  cmd_rd_sel <= bus.dm_rd_sel;
                  cmd_lane   <= bus.addr[1:0];
                  in_ready_q <= 1'b0;
                  if (in_misalign) begin
                     state       <= S_DONE;
                     out_valid_q <= 1'b1;
                     rdata_q     <= 32'h0000_0000;
                     err_q       <= 1'b1;
                  end else if (in_is_load || in_is_store) begin
                     state       <= S_REQ;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= in_is_store;
                     mem_addr_q  <= {bus.addr[31:2], 2'b00};
                     mem_wstrb_q <= in_wstrb;
                     mem_wdata_q <= in_wdata_rep;
                  end else begin
                     state       <= S_DONE;
                     out_valid_q <= 1'b1;
                     rdata_q     <= 32'h0000_0000;
                     err_q       <= 1'b0;
                  end
               end
            end

            S_REQ: begin
               // mem_rvalid is deliberately not looked at here.
               if (bus.mem_gnt) begin
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_wstrb_q <= 4'b0000;
                  if (cmd_is_load) begin
                     state <= S_WAIT;
                  end else begin
                     // Store: rdata keeps its old value.
                     state       <= S_DONE;
                     out_valid_q <= 1'b1;
                     err_q       <= 1'b0;
                  end
               end
            end

            S_WAIT: begin
               if (bus.mem_rvalid) begin
                  state       <= S_DONE;
                  out_valid_q <= 1'b1;
                  rdata_q     <= load_extract(cmd_rd_sel, cmd_lane, bus.mem_rdata);
                  err_q       <= 1'b0;
               end
            end

            S_DONE: begin
               if (bus.out_ready) begin
                  state       <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.rdata     = rdata_q;
   assign bus.err       = err_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wstrb = mem_wstrb_q;
   assign dbg_state     = state;

endmodule

// File: tb/tb_ysyx_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_lsu -- self-checking bench for ysyx_lsu.
//
// Directed cases for the documented examples, a reset-during-WAIT abort, and
// a block of randomized commands. Expected results come from a small
// arithmetic reference model; result data goes through an expected queue.
// Honours YSYX_LSU_MISALIGN_CHECK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ysyx_lsu;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   ysyx_lsu_if bus ();

   ysyx_lsu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic ref_is_load(input logic [2:0] sel);
      return (sel >= 3'd1) && (sel <= 3'd5);
   endfunction

   function automatic logic ref_misalign(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a);
`ifdef YSYX_LSU_MISALIGN_CHECK_EN
      if (ref_is_load(rd)) begin
         if (rd == 3'd3 || rd == 3'd4) return (a % 2) != 0;
         if (rd == 3'd5) return (a % 4) != 0;
         return 1'b0;
      end
      if (wr == 2'd2) return (a % 2) != 0;
      if (wr == 2'd3) return (a % 4) != 0;
      return 1'b0;
`else
      return (rd == 3'd7) && (wr == 2'd3) && (a == 32'd1) && 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] v;
      int unsigned sh;
      v = 32'd0;
      if (sel == 3'd1 || sel == 3'd2) begin
         sh = (a % 4) * 8;
         v  = (w >> sh) & 32'hFF;
         if (sel == 3'd1 && v >= 32'd128) v = v - 32'd256;
      end else if (sel == 3'd3 || sel == 3'd4) begin
         sh = ((a / 2) % 2) * 16;
         v  = (w >> sh) & 32'hFFFF;
         if (sel == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
      end else if (sel == 3'd5) begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_strb(input logic [1:0] wr, input logic [31:0] a);
      if (wr == 2'd1) return 32'd1 << (a % 4);
      if (wr == 2'd2) return 32'd3 << (((a / 2) % 2) * 2);
      return 32'd15;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] wr, input logic [31:0] d);
      if (wr == 2'd1) return (d & 32'hFF) * 32'h0101_0101;
      if (wr == 2'd2) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   // ---------------- driver ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input string tag, input logic [2:0] rd, input logic [1:0] wr,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                          input int gnt_dly, input int rv_dly, input int rdy_dly);
      logic        ld, st, mis, has_res;
      logic [31:0] exp_err;
      ld      = ref_is_load(rd);
      st      = (wr != 2'd0) && !ld;
      mis     = ref_misalign(rd, wr, a);
      exp_err = mis ? 32'd1 : 32'd0;
      has_res = !st || mis;
      if (has_res) exp_q.push_back(mis ? 32'd0 : (ld ? ref_load(rd, a, word) : 32'd0));

      check({tag, "_in_ready_idle"}, bus.in_ready, 32'd1);
      bus.in_valid  = 1'b1;
      bus.dm_rd_sel = rd;
      bus.dm_wr_sel = wr;
      bus.addr      = a;
      bus.wdata     = wd;
      tick();
      bus.in_valid  = 1'b0;
      bus.dm_rd_sel = 3'($urandom_range(0, 7));
      bus.dm_wr_sel = 2'($urandom_range(0, 3));
      bus.addr      = $urandom;
      bus.wdata     = $urandom;

      if ((ld || st) && !mis) begin
         for (int i = 0; i <= gnt_dly; i++) begin
            check({tag, "_mem_req"},   bus.mem_req,   32'd1);
            check({tag, "_mem_addr"},  bus.mem_addr,  a & 32'hFFFF_FFFC);
            check({tag, "_mem_we"},    bus.mem_we,    st ? 32'd1 : 32'd0);
            check({tag, "_mem_wstrb"}, bus.mem_wstrb, st ? ref_strb(wr, a) : 32'd0);
            if (st) check({tag, "_mem_wdata"}, bus.mem_wdata, ref_wdata(wr, wd));
            check({tag, "_early_out_valid"}, bus.out_valid, 32'd0);
            if (i == gnt_dly) begin
               bus.mem_gnt = 1'b1;
            end else if (ld) begin
               bus.mem_rvalid = 1'b1;       // must be ignored before grant
               bus.mem_rdata  = $urandom;
            end
            tick();
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
         end
         check({tag, "_req_dropped"}, bus.mem_req, 32'd0);
         if (ld) begin
            for (int j = 0; j < rv_dly; j++) begin
               check({tag, "_wait_out_valid"}, bus.out_valid, 32'd0);
               tick();
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = word;
            tick();
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
         end
      end else begin
         check({tag, "_no_mem_req"}, bus.mem_req, 32'd0);
      end

      check({tag, "_out_valid"}, bus.out_valid, 32'd1);
      for (int k = 0; k < rdy_dly; k++) begin
         check({tag, "_hold_in_ready"}, bus.in_ready, 32'd0);
         if (has_res) check({tag, "_hold_rdata"}, bus.rdata, exp_q[0]);
         check({tag, "_hold_err"}, bus.err, exp_err);
         tick();
         check({tag, "_hold_out_valid"}, bus.out_valid, 32'd1);
      end
      bus.out_ready = 1'b1;
      if (has_res) check({tag, "_rdata"}, bus.rdata, exp_q.pop_front());
      check({tag, "_err"}, bus.err, exp_err);
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_out_valid_drop"}, bus.out_valid, 32'd0);
      check({tag, "_in_ready_back"}, bus.in_ready, 32'd1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.dm_rd_sel  = 3'd0;
      bus.dm_wr_sel  = 2'd0;
      bus.addr       = 32'd0;
      bus.wdata      = 32'd0;
      bus.out_ready  = 1'b0;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'd0;

      // Reset state
      repeat (3) tick();
      check("rst_in_ready",  bus.in_ready,  32'd1);
      check("rst_out_valid", bus.out_valid, 32'd0);
      check("rst_mem_req",   bus.mem_req,   32'd0);
      check("rst_rdata",     bus.rdata,     32'd0);
      check("rst_err",       bus.err,       32'd0);
      rst_n = 1'b1;
      tick();
      check("rel_in_ready", bus.in_ready, 32'd1);

      // lb with sign extension from the top byte
      run_txn("lb_sext", 3'd1, 2'd0, 32'h8000_0003, 32'h0, 32'h85FF_1234, 0, 0, 0);
      check("lb_sext_model", ref_load(3'd1, 32'h8000_0003, 32'h85FF_1234), 32'hFFFF_FF85);

      // sh upper half, grant after two cycles (request held three cycles)
      run_txn("sh_gnt2", 3'd0, 2'd2, 32'h8000_0006, 32'h0000_BEEF, 32'h0, 2, 0, 0);

      // lhu with writeback stalled three cycles
      run_txn("lhu_stall", 3'd4, 2'd0, 32'h0000_0010, 32'h0, 32'h0000_F00D, 0, 0, 3);

      // no-op command
      run_txn("noop", 3'd0, 2'd0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);

      // load and store both selected: treated as a load
      run_txn("ld_wins", 3'd2, 2'd3, 32'h0000_0021, 32'hCAFE_F00D, 32'hA1B2_C3D4, 1, 1, 1);

      // misaligned word load
      run_txn("lw_mis", 3'd5, 2'd0, 32'h0000_0102, 32'h0, 32'h1357_9BDF, 0, 0, 0);

      // misaligned halfword load and store
      run_txn("lh_odd", 3'd3, 2'd0, 32'h0000_0205, 32'h0, 32'h8001_7F02, 0, 2, 0);
      run_txn("sh_odd", 3'd0, 2'd2, 32'h0000_0203, 32'h0000_5AA5, 32'h0, 1, 0, 1);

      // reset while waiting for read data
      run_txn("pre_rst", 3'd5, 2'd0, 32'h0000_0300, 32'h0, 32'h7654_3210, 0, 0, 0);
      bus.in_valid  = 1'b1;
      bus.dm_rd_sel = 3'd5;
      bus.dm_wr_sel = 2'd0;
      bus.addr      = 32'h0000_0400;
      tick();
      bus.in_valid  = 1'b0;
      bus.mem_gnt   = 1'b1;
      tick();
      bus.mem_gnt   = 1'b0;
      check("abort_in_wait_req", bus.mem_req, 32'd0);
      rst_n = 1'b0;
      #1;
      check("abort_mem_req",   bus.mem_req,   32'd0);
      check("abort_out_valid", bus.out_valid, 32'd0);
      check("abort_rdata",     bus.rdata,     32'd0);
      check("abort_err",       bus.err,       32'd0);
      tick();
      rst_n = 1'b1;
      bus.mem_rvalid = 1'b1;           // stale read data after release
      bus.mem_rdata  = 32'hFFFF_FFFF;
      tick();
      bus.mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stale_out_valid", bus.out_valid, 32'd0);
         check("stale_mem_req",   bus.mem_req,   32'd0);
         check("stale_in_ready",  bus.in_ready,  32'd1);
         tick();
      end

      // randomized commands
      for (int n = 0; n < 60; n++) begin
         run_txn("rnd", 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                 $urandom, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      end

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ysyx_lsu.md
YSYX_LSU -- requirements
Module: ysyx_LSU

Interface
REQ-001 SHALL: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: in_valid/in_ready  input/output  1/1  command handshake from execute stage.
REQ-004 SHALL: dm_rd_sel  input  3  load select: 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, others no-load.
REQ-005 SHALL: dm_wr_sel  input  2  store select: 01 sb, 10 sh, 11 sw, 00 no-store.
REQ-006 SHALL: addr  input  32  byte address (ALU result); wdata  input  32  store data (rs2).
REQ-007 SHALL: out_valid/out_ready  output/input  1/1  result handshake to writeback; rdata  output  32  load result; err  output  1  misalignment flag.
REQ-008 SHALL: mem_req, mem_we  output  1  bus request, write enable; mem_addr  output  32; mem_wdata  output  32; mem_wstrb  output  4.
REQ-009 SHALL: mem_gnt, mem_rvalid  input  1  grant, read data valid; mem_rdata  input  32.

Function
REQ-010 SHALL implement FSM IDLE, REQ, WAIT, DONE; in_ready=1 only in IDLE.
REQ-011 SHALL, on in_valid&in_ready, register dm_rd_sel, dm_wr_sel, addr, wdata; next state REQ for a memory op, else DONE with rdata=0, err=0.
REQ-012 SHALL treat a command with both a valid load and a valid store select as a load; store ignored.
REQ-013 SHALL in REQ drive mem_req=1 with stable mem_addr={addr[31:2],2'b00}, mem_we, mem_wstrb, mem_wdata until mem_gnt; mem_req=0 in all other states.
REQ-014 SHALL on grant go to DONE for store, WAIT for load; mem_rvalid before grant ignored.
REQ-015 SHALL in WAIT capture mem_rdata on mem_rvalid (earliest cycle after grant) into rdata, then go to DONE.
REQ-016 SHALL extract loads: byte lane addr[1:0], half lane addr[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw whole word.
REQ-017 SHALL form stores: sb wstrb=4'b0001<<addr[1:0], byte replicated to all lanes; sh wstrb=4'b0011<<{addr[1],1'b0}, half replicated; sw wstrb=4'b1111; loads wstrb=0.
REQ-018 SHALL in DONE hold out_valid=1, rdata, err stable until out_ready; then IDLE; out_valid=0 elsewhere.
REQ-019 SHALL give minimum latency accept->out_valid: 1 cycle non-memory, 2 cycles store, 3 cycles load (gnt and rvalid immediate).
REQ-020 SHALL keep rdata unchanged for stores (previous value not guaranteed; writeback ignores it).

Reset
REQ-021 SHALL on rst_n=0, at any state including mid-transaction, force IDLE, mem_req=0, out_valid=0, rdata=0, err=0, registered command cleared; in_ready=1 after release.
REQ-022 SHALL not complete or re-issue an aborted bus transaction after reset release.

Configuration
REQ-023 SHALL provide macro YSYX_LSU_MISALIGN_CHECK_EN.
REQ-024 SHALL, with macro defined, flag lh/lhu/sh with addr[0]=1 and lw/sw with addr[1:0]!=0: skip REQ, go directly to DONE with err=1, rdata=0, no bus request.
REQ-025 SHALL, with macro undefined, tie err=0 and perform access using lane rules of REQ-016/017 with addr[1:0] unchanged (half at addr[0]=1 uses addr[1] lane only).

Verification
REQ-026 SHALL: lb addr=0x80000003, mem_rdata=0x85FF1234 -> mem_addr=0x80000000, wstrb=0, rdata=0xFFFFFF85.
REQ-027 SHALL: sh addr=0x80000006, wdata=0x0000BEEF, gnt after 2 cycles -> mem_req held 3 cycles, wstrb=4'b1100, mem_wdata=0xBEEFBEEF, out_valid 1 cycle after gnt.
REQ-028 SHALL: lhu addr=0x10, mem_rdata=0x0000F00D, out_ready low 3 cycles -> rdata=0x0000F00D held, in_ready=0 until handshake.
REQ-029 SHALL: dm_rd_sel=0, dm_wr_sel=0 -> no mem_req, out_valid next cycle, rdata=0.
REQ-030 SHALL: rst_n low during WAIT -> mem_req=0, out_valid=0 immediately; stale mem_rvalid after release ignored.
REQ-031 SHALL: macro defined, lw addr=0x102 -> no mem_req, out_valid next cycle, err=1; undefined -> bus read at 0x100, err=0.
